// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB master arbiter.
package apb_arb_pkg;

  localparam int APB_AW          = 32;
  localparam int APB_DW          = 32;
  localparam int TIMEOUT_CYC_DEF = 256;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } arb_state_e;

  // Sized for the default bus; the top casts to its own AW/DW.
  typedef struct packed {
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
    logic              write;
  } apb_req_t;

endpackage

// File: rtl/apb_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at/after ptr, wrapping.
module apb_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int unsigned j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = (32'(ptr) + i) % 32'(NREQ);
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NREQ requesters.
// Optional ACCESS-phase timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int AW          = APB_AW,
  parameter int DW          = APB_DW,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NREQ-1:0]  req_valid_i,
  output logic [NREQ-1:0]  req_ready_o,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_wdata_i,
  input  logic [NREQ-1:0]  req_write_i,
  output logic [NREQ-1:0]  rsp_valid_o,
  output logic [DW-1:0]    rsp_rdata_o,
  output logic             rsp_err_o,
  output logic [AW-1:0]    paddr_o,
  output logic [DW-1:0]    pwdata_o,
  output logic             pwrite_o,
  output logic             psel_o,
  output logic             penable_o,
  input  logic [DW-1:0]    prdata_i,
  input  logic             pready_i,
  input  logic             pslverr_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  apb_req_t        req_q;
  logic [NREQ-1:0] gnt_q;
  logic [IW-1:0]   ptr_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            abort;

  apb_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .valid (req_valid_i),
    .ptr   (ptr_q),
    .grant (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q <= '0;
    end else if (state_q == SETUP) begin
      tmo_q <= '0;
    end else if (state_q == ACCESS && !pready_i) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  // Fires on the last permitted ACCESS cycle; a pready on that same cycle still completes normally.
  assign abort = (state_q == ACCESS) && !pready_i && (tmo_q == CW'(TIMEOUT_CYC - 1));
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_any) begin
        req_q.addr  <= APB_AW'(req_addr_i[pick_idx*AW +: AW]);
        req_q.wdata <= APB_DW'(req_wdata_i[pick_idx*DW +: DW]);
        req_q.write <= req_write_i[pick_idx];
        gnt_q       <= pick_gnt;
        ptr_q       <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (state_q == ACCESS) begin
        if (pready_i) begin
          rdata_q <= req_q.write ? '0 : prdata_i;
          err_q   <= pslverr_i;
        end else if (abort) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    pwrite_o    = 1'b0;
    paddr_o     = '0;
    pwdata_o    = '0;
    unique case (state_q)
      IDLE: begin
        // Grant is combinational; masked while reset holds so every output reads 0.
        req_ready_o = rst_i ? '0 : pick_gnt;
        if (pick_any) state_d = SETUP;
      end
      SETUP, ACCESS: begin
        psel_o    = 1'b1;
        penable_o = (state_q == ACCESS);
        pwrite_o  = req_q.write;
        paddr_o   = AW'(req_q.addr);
        pwdata_o  = req_q.write ? DW'(req_q.wdata) : '0;
        if (state_q == SETUP)          state_d = ACCESS;
        else if (pready_i || abort)    state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = gnt_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed vectors, corner sequences, random vs model.
`timescale 1ns/1ps
module tb_apb_master_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NREQ-1:0]   req_valid_i, req_ready_o, req_write_i, rsp_valid_o;
  logic [NREQ*AW-1:0] req_addr_i;
  logic [NREQ*DW-1:0] req_wdata_i;
  logic [DW-1:0]     rsp_rdata_o;
  logic              rsp_err_o;
  logic [AW-1:0]     paddr_o;
  logic [DW-1:0]     pwdata_o, prdata_i;
  logic              pwrite_o, psel_o, penable_o, pready_i, pslverr_i;

  int checks = 0;
  int errors = 0;

  apb_master_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_write_i (req_write_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .paddr_o     (paddr_o),
    .pwdata_o    (pwdata_o),
    .pwrite_o    (pwrite_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i),
    .pslverr_i   (pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  // APB slave: inserts slv_waits wait states, then returns slv_prdata/slv_err.
  int unsigned   slv_waits = 0;
  logic [DW-1:0] slv_prdata = '0;
  logic          slv_err = 1'b0;
  int unsigned   slv_cnt;

  initial begin
    pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0; slv_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (psel_o && !penable_o) begin
        slv_cnt = slv_waits; pready_i = 1'b0;
      end else if (psel_o && penable_o) begin
        if (slv_cnt == 0) begin
          pready_i = 1'b1; prdata_i = slv_prdata; pslverr_i = slv_err;
        end else begin
          slv_cnt--; pready_i = 1'b0;
        end
      end else begin
        pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = $urandom;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_write_i[r]          = w;
    req_addr_i[r*AW +: AW]  = a;
    req_wdata_i[r*DW +: DW] = d;
  endtask

  task automatic reset_dut();
    req_valid_i = '0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  typedef struct {
    int          req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        serr;
    logic [3:0]  exp_rsp;
    logic [31:0] exp_pwdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v, input int k);
    int lat;
    @(posedge clk_i); #1;
    slv_waits = v.waits; slv_prdata = v.prdata; slv_err = v.serr;
    set_req(v.req, v.wr, v.addr, v.wdata);
    req_valid_i = '0;
    req_valid_i[v.req] = 1'b1;
    @(negedge clk_i);
    chk($sformatf("v%0d ready", k), req_ready_o, v.exp_rsp);
    @(posedge clk_i); #1;
    req_valid_i = '0;
    @(negedge clk_i);
    chk($sformatf("v%0d setup ctl", k), {psel_o, penable_o, pwrite_o}, {2'b10, v.wr});
    chk($sformatf("v%0d setup addr", k), paddr_o, v.addr);
    chk($sformatf("v%0d setup wdata", k), pwdata_o, v.exp_pwdata);
    @(negedge clk_i);
    chk($sformatf("v%0d access ctl", k), {psel_o, penable_o}, 2'b11);
    lat = 2;
    while (rsp_valid_o == '0 && lat < 400) begin
      @(negedge clk_i);
      lat++;
    end
    chk($sformatf("v%0d latency", k), lat, v.exp_lat);
    chk($sformatf("v%0d rsp", k), {rsp_err_o, rsp_valid_o, rsp_rdata_o},
        {v.exp_err, v.exp_rsp, v.exp_rdata});
    chk($sformatf("v%0d rsp apb idle", k), {psel_o, penable_o, paddr_o}, '0);
  endtask

  vec_t vecs[$];

  initial begin : main
    int gi[8];
    int gc[8];
    int ng;
    logic        pend[NREQ];
    logic [31:0] ra[NREQ], rd[NREQ];
    logic        rw[NREQ];
    int          mptr, next_free, t0, w, g;
    logic        active;
    logic [3:0]  cur_g, exp_ready, exp_rsp;
    logic [31:0] cur_a, cur_d, exp_rd;
    logic        cur_w, exp_er, exp_psel, exp_pen;

    vecs.push_back('{0, 1'b1, 32'h080, 32'hA5,       0, 32'h1234,     1'b0, 4'b0001, 32'hA5, 32'h0,        1'b0, 3});
    vecs.push_back('{1, 1'b0, 32'h000, 32'h5555_5555, 3, 32'hDEADBEEF, 1'b0, 4'b0010, 32'h0,  32'hDEADBEEF, 1'b0, 6});
    vecs.push_back('{2, 1'b1, 32'h084, 32'h1,        0, 32'h9999,     1'b1, 4'b0100, 32'h1,  32'h0,        1'b1, 3});
    vecs.push_back('{3, 1'b0, 32'h090, 32'h77,       1, 32'hCAFEF00D, 1'b1, 4'b1000, 32'h0,  32'hCAFEF00D, 1'b1, 4});

    // Reset state, with requests pending to show ready stays low.
    rst_i = 1'b1;
    req_valid_i = '1; req_write_i = '0; req_addr_i = '0; req_wdata_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset ctl", {req_ready_o, rsp_valid_o, psel_o, penable_o, pwrite_o, rsp_err_o}, '0);
    chk("reset paddr", paddr_o, '0);
    chk("reset pwdata", pwdata_o, '0);
    chk("reset rdata", rsp_rdata_o, '0);
    @(posedge clk_i); #1;
    req_valid_i = '0;
    rst_i = 1'b0;

    foreach (vecs[k]) run_vec(vecs[k], k);

    @(negedge clk_i);
    chk("rsp hold", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, {4'b0000, 1'b1, 32'hCAFEF00D});

`ifdef APB_ARB_TIMEOUT_EN
    begin
      vec_t tv;
      tv = '{0, 1'b0, 32'h0C0, 32'h0, 1000, 32'h1111_2222, 1'b0, 4'b0001, 32'h0, 32'h0, 1'b1, 258};
      run_vec(tv, 99);
    end
`endif

    // Round robin with all four requesters held valid.
    reset_dut();
    @(posedge clk_i); #1;
    slv_waits = 0; slv_err = 1'b0;
    for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, 32'h100 + 32'(4 * r), 32'(r));
    req_valid_i = '1;
    ng = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      chk($sformatf("rr onehot c%0d", c), ($countones(req_ready_o) <= 1) && ($countones(rsp_valid_o) <= 1), 1'b1);
      if (req_ready_o != '0 && ng < 8) begin
        for (int b = 0; b < NREQ; b++) if (req_ready_o[b]) gi[ng] = b;
        gc[ng] = c;
        ng++;
      end
    end
    req_valid_i = '0;
    chk("rr grant count", ng, 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr order %0d", k), gi[k], k % 4);
      if (k > 0) chk($sformatf("rr spacing %0d", k), gc[k] - gc[k-1], 4);
    end

    // Asynchronous reset in the middle of an ACCESS phase.
    reset_dut();
    @(posedge clk_i); #1;
    slv_waits = 20; slv_prdata = 32'h5A5A; slv_err = 1'b0;
    set_req(1, 1'b0, 32'h010, 32'h0);
    req_valid_i = 4'b0010;
    @(negedge clk_i);
    chk("rst ready", req_ready_o, 4'b0010);
    @(posedge clk_i); #1;
    req_valid_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst in access", {psel_o, penable_o}, 2'b11);
    #2 rst_i = 1'b1;
    #1 chk("rst async drop", {psel_o, penable_o}, 2'b00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk($sformatf("rst no rsp %0d", c), rsp_valid_o, '0);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    slv_waits = 0; slv_prdata = 32'h600D;
    set_req(0, 1'b0, 32'h020, 32'h0);
    set_req(3, 1'b0, 32'h030, 32'h0);
    req_valid_i = 4'b1001;
    @(negedge clk_i);
    chk("post rst grant", req_ready_o, 4'b0001);
    @(posedge clk_i); #1;
    req_valid_i = '0;
    repeat (2) @(negedge clk_i);
    chk("post rst pre-rsp", rsp_valid_o, '0);
    @(negedge clk_i);
    chk("post rst rsp", {rsp_valid_o, rsp_rdata_o}, {4'b0001, 32'h600D});

    // Randomized traffic against a timeline model.
    reset_dut();
    for (int r = 0; r < NREQ; r++) pend[r] = 1'b0;
    mptr = 0; next_free = 0; active = 1'b0; t0 = 0; w = 0; g = 0;
    cur_g = '0; cur_a = '0; cur_d = '0; cur_w = 1'b0; exp_rd = '0; exp_er = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk_i); #1;
      for (int r = 0; r < NREQ; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1; ra[r] = $urandom; rd[r] = $urandom; rw[r] = 1'($urandom_range(0, 1));
          set_req(r, rw[r], ra[r], rd[r]);
        end
        req_valid_i[r] = pend[r];
      end
      @(negedge clk_i);
      exp_ready = '0;
      if (n >= next_free) begin
        for (int k = 0; k < NREQ; k++) begin
          int c;
          c = (mptr + k) % NREQ;
          if (pend[c] && exp_ready == '0) begin
            exp_ready[c] = 1'b1;
            g = c;
          end
        end
      end
      exp_psel = active && (n >= t0 + 1) && (n <= t0 + 2 + w);
      exp_pen  = active && (n >= t0 + 2) && (n <= t0 + 2 + w);
      exp_rsp  = (active && n == t0 + 3 + w) ? cur_g : 4'b0000;
      chk($sformatf("rnd c%0d ctl", n), {req_ready_o, psel_o, penable_o, rsp_valid_o},
          {exp_ready, exp_psel, exp_pen, exp_rsp});
      if (exp_psel) begin
        chk($sformatf("rnd c%0d addr", n), {pwrite_o, paddr_o}, {cur_w, cur_a});
        chk($sformatf("rnd c%0d wdata", n), pwdata_o, cur_w ? cur_d : 32'h0);
      end
      if (exp_rsp != '0)
        chk($sformatf("rnd c%0d rsp", n), {rsp_err_o, rsp_rdata_o}, {exp_er, exp_rd});
      if (exp_ready != '0) begin
        active = 1'b1; t0 = n; w = $urandom_range(0, 3);
        cur_g = exp_ready; cur_a = ra[g]; cur_d = rd[g]; cur_w = rw[g];
        pend[g] = 1'b0;
        mptr = (g + 1) % NREQ;
        next_free = n + 4 + w;
        slv_waits = w; slv_prdata = $urandom; slv_err = 1'($urandom_range(0, 1));
        exp_rd = cur_w ? 32'h0 : slv_prdata;
        exp_er = slv_err;
      end
      if (errors > 50) break;
    end
    req_valid_i = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
